// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port among NUM_MASTERS masters.
// An owner keeps the bus until it drops cyc; a hold watchdog reclaims it from unacknowledged owners.
module wishbone_arbiter #(
    parameter int NUM_MASTERS   = 2,
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_BYTES    = 1,
    parameter int MAX_HOLD      = 64
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic [NUM_MASTERS-1:0]               m_cyc_i,
    input  logic [NUM_MASTERS-1:0]               m_stb_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i,
    input  logic [NUM_MASTERS*DATA_BYTES-1:0]    m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]             m_cti_i,
    output logic [NUM_MASTERS-1:0]               m_ack_o,
    output logic [NUM_MASTERS-1:0]               m_busy_o,
    output logic [DATA_WIDTH-1:0]                m_dat_o,
    output logic                                 s_cyc_o,
    output logic                                 s_stb_o,
    output logic                                 s_we_o,
    output logic [ADDRESS_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]                s_dat_o,
    output logic [DATA_BYTES-1:0]                s_sel_o,
    output logic [2:0]                           s_cti_o,
    input  logic                                 s_ack_i,
    input  logic [DATA_WIDTH-1:0]                s_dat_i,
    output logic [NUM_MASTERS-1:0]               grant_o,
    output logic                                 watchdog_o
);

    localparam int LW = $clog2(NUM_MASTERS);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [LW-1:0] LAST_RST   = LW'(NUM_MASTERS - 1);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [LW-1:0]          last_q, last_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic [NUM_MASTERS-1:0] mask_q, mask_d;
    logic                   watchdog_q, watchdog_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] win_onehot;
    logic [LW-1:0]          winner;
    logic                   found;
    logic                   owner_cyc;
    logic [HW-1:0]          hold_inc;

    // Round-robin pick: scan last+1, last+2, ... so the previous owner comes last.
    always_comb begin
        req        = m_cyc_i & ~mask_q;
        found      = 1'b0;
        winner     = last_q;
        win_onehot = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            if (!found && req[(int'(last_q) + i) % NUM_MASTERS]) begin
                found  = 1'b1;
                winner = LW'((int'(last_q) + i) % NUM_MASTERS);
            end
        end
        if (found) begin
            win_onehot[winner] = 1'b1;
        end
    end

    always_comb begin
        owner_cyc  = |(m_cyc_i & grant_q);
        hold_inc   = hold_cnt_q + 1'b1;
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        mask_d     = mask_q & m_cyc_i;
        watchdog_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = GRANTED;
                    grant_d    = win_onehot;
                    last_d     = winner;
                    hold_cnt_d = '0;
                end
            end
            GRANTED: begin
                // A normal release outranks a simultaneous watchdog expiry.
                if (!owner_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (s_ack_i) begin
                    hold_cnt_d = '0;
                end else if (hold_inc == HOLD_LIMIT) begin
                    mask_d     = mask_d | grant_q;
                    watchdog_d = 1'b1;
                    state_d    = IDLE;
                    grant_d    = '0;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_inc;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= LAST_RST;
            hold_cnt_q <= '0;
            mask_q     <= '0;
            watchdog_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            mask_q     <= mask_d;
            watchdog_q <= watchdog_d;
        end
    end

    // grant_q is all zero in IDLE, so the one-hot mux naturally forces the slave side to 0.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                s_cyc_o = m_cyc_i[k];
                s_stb_o = m_stb_i[k];
                s_we_o  = m_we_i[k];
                s_adr_o = m_adr_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                s_dat_o = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                s_sel_o = m_sel_i[k*DATA_BYTES +: DATA_BYTES];
                s_cti_o = m_cti_i[k*3 +: 3];
            end
        end
    end

    assign m_ack_o    = grant_q & {NUM_MASTERS{s_ack_i}};
    assign m_busy_o   = {NUM_MASTERS{state_q == GRANTED}} & ~grant_q;
    assign m_dat_o    = s_dat_i;
    assign grant_o    = grant_q;
    assign watchdog_o = watchdog_q;

endmodule
